// File: rtl/battery_soc_estimator_if.sv
// battery_soc_estimator_if: sample/level bus between battery front end and SOC estimator
interface battery_soc_estimator_if;
    logic [7:0] voltage;
    logic       sample_valid;
    logic       sample_ready;
    logic       charging;
    logic [7:0] battery_level;
    logic       level_valid;
    logic       undervolt_flag;
    modport master (
        output voltage, sample_valid, charging,
        input  sample_ready, battery_level, level_valid, undervolt_flag
    );
    modport slave (
        input  voltage, sample_valid, charging,
        output sample_ready, battery_level, level_valid, undervolt_flag
    );
endinterface

// File: rtl/battery_soc_estimator.sv
// battery_soc_estimator: block-averaged voltage to slew-limited 0-100% state of charge
module battery_soc_estimator #(
    parameter int AVG_LOG2 = 2,
    parameter int V_EMPTY  = 150,
    parameter int V_FULL   = 200,
    parameter int V_CUTOFF = 140,
    parameter int MAX_STEP = 5
) (
    input logic clk,
    input logic reset,
    battery_soc_estimator_if.slave bus
);
    localparam logic [1:0] ACCUM  = 2'd0;
    localparam logic [1:0] CALC   = 2'd1;
    localparam logic [1:0] DIV    = 2'd2;
    localparam logic [1:0] UPDATE = 2'd3;
    localparam int SW = 8 + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);
    localparam logic [7:0] VE   = 8'(V_EMPTY);
    localparam logic [7:0] VF   = 8'(V_FULL);
    localparam logic [7:0] VC   = 8'(V_CUTOFF);
    localparam logic [7:0] STEP = 8'(MAX_STEP);
    localparam logic [8:0] DV   = 9'(V_FULL - V_EMPTY);

    logic [1:0]    state;
    logic [SW-1:0] sum;
    logic [CW-1:0] cnt;
    logic [3:0]    dcnt;
    logic [14:0]   q;
    logic [7:0]    rem;
    logic [7:0]    lvl;
    logic          lv;
    logic          uv;
    logic          first_done;
    logic [7:0]    avg;
    logic [8:0]    rs;
    logic          ge;
    logic          take;
    logic [7:0]    tgt;
    logic [7:0]    up;
    logic [7:0]    dn;
    logic [14:0]   num;

    assign avg  = 8'(sum >> AVG_LOG2);
    assign take = bus.sample_valid && state == ACCUM;
    assign rs   = {rem, q[14]};
    assign ge   = rs >= DV;
    // q doubles as the quotient register and, on the clamp path, holds the target directly
    assign tgt  = q[7:0];
    assign num  = {7'd0, avg - VE} * 15'd100;
    assign up   = (tgt > lvl) ? ((tgt - lvl > STEP) ? lvl + STEP : tgt) : lvl;
    assign dn   = (tgt < lvl) ? ((lvl - tgt > STEP) ? lvl - STEP : tgt) : lvl;

    assign bus.sample_ready   = state == ACCUM;
    assign bus.battery_level  = lvl;
    assign bus.level_valid    = lv;
    assign bus.undervolt_flag = uv;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ACCUM;
            sum        <= '0;
            cnt        <= '0;
            dcnt       <= '0;
            q          <= '0;
            rem        <= '0;
            lvl        <= '0;
            lv         <= 1'b0;
            uv         <= 1'b0;
            first_done <= 1'b0;
        end else begin
            lv <= 1'b0;
            if (take && bus.voltage < VC)
                uv <= 1'b1;
            else if (state == UPDATE && avg >= VE)
                uv <= 1'b0;
            case (state)
                ACCUM: if (take) begin
                    sum <= sum + SW'(bus.voltage);
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST)
                        state <= CALC;
                end
                CALC: begin
                    rem  <= '0;
                    dcnt <= '0;
                    q     <= (avg <= VE) ? 15'd0 : (avg >= VF) ? 15'd100 : num;
                    state <= (avg <= VE || avg >= VF) ? UPDATE : DIV;
                end
                DIV: begin
                    rem  <= ge ? 8'(rs - DV) : rs[7:0];
                    q    <= {q[13:0], ge};
                    dcnt <= dcnt + 1'b1;
                    if (dcnt == 4'd14)
                        state <= UPDATE;
                end
                default: begin
                    lvl        <= !first_done ? tgt : bus.charging ? up : dn;
                    first_done <= 1'b1;
                    lv         <= 1'b1;
                    sum        <= '0;
                    cnt        <= '0;
                    state      <= ACCUM;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_battery_soc_estimator.sv
// tb_battery_soc_estimator: directed scoreboard bench for the SOC estimator
module tb_battery_soc_estimator;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    battery_soc_estimator_if bus ();
    battery_soc_estimator dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        int lvl;
        int uv;
        int lat;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int m_lvl = 0;
    int m_uv = 0;
    bit m_first = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model(input int sum, input bit chg, input bit low);
        int avg, t, d;
        exp_t e;
        avg = sum / 4;
        t = (avg <= 150) ? 0 : (avg >= 200) ? 100 : (avg - 150) * 100 / 50;
        if (!m_first) m_lvl = t;
        else if (chg && t > m_lvl) begin
            d = t - m_lvl;
            m_lvl += (d > 5) ? 5 : d;
        end else if (!chg && t < m_lvl) begin
            d = m_lvl - t;
            m_lvl -= (d > 5) ? 5 : d;
        end
        m_first = 1;
        m_uv = (avg >= 150) ? 0 : (m_uv | int'(low));
        e.lvl = m_lvl;
        e.uv = m_uv;
        e.lat = (avg <= 150 || avg >= 200) ? 2 : 17;
        sb.push_back(e);
    endfunction

    task automatic drive_block(input logic [7:0] a, b, c, d, input logic chg);
        logic [7:0] v[4];
        int sum = 0;
        bit low = 0;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        bus.charging = chg;
        for (int i = 0; i < 4; i++) begin
            bus.voltage = v[i];
            bus.sample_valid = 1'b1;
            chk("ready_accum", 32'(bus.sample_ready), 1);
            @(negedge clk);
            sum += int'(v[i]);
            if (v[i] < 8'd140) begin
                low = 1;
                chk("uv_set", 32'(bus.undervolt_flag), 1);
            end
        end
        bus.sample_valid = 1'b0;
        model(sum, chg, low);
    endtask

    task automatic wait_result();
        exp_t e;
        int n = 0;
        bit found = 0;
        chk("ready_busy", 32'(bus.sample_ready), 0);
        while (!found && n < 40) begin
            @(negedge clk);
            n++;
            found = bus.level_valid;
        end
        chk("lv_seen", 32'(found), 1);
        if (found && sb.size() > 0) begin
            e = sb.pop_front();
            chk("latency", n, e.lat);
            chk("level", 32'(bus.battery_level), e.lvl);
            chk("uv", 32'(bus.undervolt_flag), e.uv);
            @(negedge clk);
            chk("lv_pulse", 32'(bus.level_valid), 0);
        end
    endtask

    initial begin
        exp_t e;
        int acc, pulses, guard, seen;
        reset = 1'b1;
        bus.voltage = '0;
        bus.sample_valid = 1'b0;
        bus.charging = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_level", 32'(bus.battery_level), 0);
        chk("rst_lv", 32'(bus.level_valid), 0);
        chk("rst_uv", 32'(bus.undervolt_flag), 0);
        chk("rst_ready", 32'(bus.sample_ready), 1);
        reset = 1'b0;
        @(negedge clk);

        drive_block(174, 175, 176, 175, 0); wait_result();
        drive_block(190, 190, 190, 190, 0); wait_result();
        drive_block(190, 190, 190, 190, 1); wait_result();
        drive_block(190, 190, 190, 190, 1); wait_result();

        guard = 0;
        while (m_lvl != 97 && guard < 20) begin
            drive_block(199, 199, 199, 199, 1); wait_result();
            guard++;
        end
        drive_block(210, 210, 210, 210, 1); wait_result();
        drive_block(170, 170, 170, 170, 0); wait_result();

        drive_block(130, 160, 160, 160, 0); wait_result();

        // continuous sample_valid: two back-to-back blocks of 21 cycles
        model(700, 0, 0);
        model(700, 0, 0);
        bus.voltage = 8'd175;
        bus.charging = 1'b0;
        bus.sample_valid = 1'b1;
        acc = 0;
        pulses = 0;
        for (int i = 1; i <= 42; i++) begin
            if (bus.sample_ready) acc++;
            @(negedge clk);
            if (bus.level_valid) begin
                pulses++;
                chk("period_pos", i, 21 * pulses);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("cont_level", 32'(bus.battery_level), e.lvl);
                end
            end
        end
        bus.sample_valid = 1'b0;
        chk("cont_accepts", acc, 8);
        chk("cont_pulses", pulses, 2);

        drive_block(130, 130, 130, 130, 0); wait_result();

        drive_block(190, 190, 190, 190, 1);
        void'(sb.pop_back());
        repeat (7) @(negedge clk);
        chk("pre_rst_uv", 32'(bus.undervolt_flag), 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_level", 32'(bus.battery_level), 0);
        chk("mid_rst_lv", 32'(bus.level_valid), 0);
        chk("mid_rst_uv", 32'(bus.undervolt_flag), 0);
        chk("mid_rst_ready", 32'(bus.sample_ready), 1);
        m_lvl = 0;
        m_uv = 0;
        m_first = 0;
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.level_valid) seen++;
        end
        chk("no_lv_after_rst", seen, 0);
        drive_block(160, 160, 160, 160, 0); wait_result();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
